// File: rtl/double_trouble_vote_ctrl_if.sv
// Purpose: bundles the voter handshakes and the decision handshake of
//          double_trouble_vote_ctrl into a single interface.
// Signals:
//   start       round request (sampled only while the controller is idle)
//   vote_valid  per-voter "vote presented"
//   vote_in     per-voter vote value
//   vote_ack    per-voter "vote accepted this cycle" (combinational)
//   busy        round in progress (collect, evaluate or waiting for the consumer)
//   voted_mask  voters whose vote was accepted in the current/last round
//   res_valid   decision available
//   res_ready   consumer takes the decision
//   result      threshold decision
//   timed_out   last round closed with at least one vote missing
// Modports: master = voters/consumer side, slave = controller side.
interface double_trouble_vote_ctrl_if;
  logic       start;
  logic [3:0] vote_valid;
  logic [3:0] vote_in;
  logic [3:0] vote_ack;
  logic       busy;
  logic [3:0] voted_mask;
  logic       res_valid;
  logic       res_ready;
  logic       result;
  logic       timed_out;

  modport master (
    output start, vote_valid, vote_in, res_ready,
    input  vote_ack, busy, voted_mask, res_valid, result, timed_out
  );

  modport slave (
    input  start, vote_valid, vote_in, res_ready,
    output vote_ack, busy, voted_mask, res_valid, result, timed_out
  );
endinterface

// File: rtl/double_trouble_vote_ctrl.sv
// Purpose: one-round-per-start vote sequencer around a 2-of-4 threshold.
//          Collects at most one vote from each of four voters within a
//          TIMEOUT-cycle window, evaluates "at least THRESH accepted 1-votes"
//          and holds the decision on a valid/ready port until taken.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; abandons any round in flight
//   bus    double_trouble_vote_ctrl_if.slave (votes in, acks and decision out)
// Parameters:
//   TIMEOUT  collect window length in cycles (1..65535)
//   THRESH   minimum number of accepted 1-votes for result = 1 (1..4)
//   TW       timer width, TIMEOUT < 2**TW
module double_trouble_vote_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int THRESH  = 2,
  parameter int TW      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  double_trouble_vote_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EVAL    = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT);
  localparam logic [2:0]    THRESH_W   = 3'(THRESH);

  state_e        state_q, state_d;
  logic [3:0]    votes_q, votes_d;
  logic [3:0]    mask_q, mask_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          res_valid_q, res_valid_d;
  logic          result_q, result_d;
  logic          timed_out_q, timed_out_d;
  logic [3:0]    ack;

  // Number of set bits in a 4-bit vector; 3 bits hold 0..4 without overflow.
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  // State and datapath registers; reset drops any round in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      votes_q     <= '0;
      mask_q      <= '0;
      timer_q     <= '0;
      res_valid_q <= 1'b0;
      result_q    <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      votes_q     <= votes_d;
      mask_q      <= mask_d;
      timer_q     <= timer_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      timed_out_q <= timed_out_d;
    end
  end

  // Next-state and output logic. Acks only exist while collecting, and a
  // voter already in the mask is never acked again, so its first value wins.
  // The window closes either when every voter has been accepted (counting
  // votes acked in this very cycle) or on the last timer cycle (timer = 1).
  always_comb begin
    state_d     = state_q;
    votes_d     = votes_q;
    mask_d      = mask_q;
    timer_d     = timer_q;
    res_valid_d = res_valid_q;
    result_d    = result_q;
    timed_out_d = timed_out_q;
    ack         = 4'b0000;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          votes_d = 4'b0000;
          mask_d  = 4'b0000;
          timer_d = TIMER_LOAD;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        ack     = bus.vote_valid & ~mask_q;
        votes_d = (votes_q & ~ack) | (bus.vote_in & ack);
        mask_d  = mask_q | ack;
        timer_d = timer_q - 1'b1;
        if (mask_d == 4'hF || timer_q == TW'(1)) begin
          state_d = EVAL;
        end
      end
      EVAL: begin
        result_d    = (popcount4(votes_q & mask_q) >= THRESH_W);
        timed_out_d = (mask_q != 4'hF);
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.vote_ack   = ack;
  assign bus.busy       = (state_q != IDLE);
  assign bus.voted_mask = mask_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.result     = result_q;
  assign bus.timed_out  = timed_out_q;

endmodule

// File: doc/double_trouble_vote_ctrl.md
Name: double_trouble_vote_ctrl

Overview:
- Sequencer around the 2-of-4 threshold datapath (DOUBLE_TROUBLE, out = 1 when at least two of four inputs are high).
- Runs one voting round per start: collects one vote from each of four requesters over per-voter valid/ack handshakes, with a timeout window.
- Feeds the latched votes (missing votes count as 0) to the threshold evaluation, then holds the decision on a valid/ready result port.
- Sits between four independent voter agents and the downstream consumer of the decision.

Parameters:
- TIMEOUT, 16: number of COLLECT cycles before the round closes; legal range 1..65535.
- THRESH, 2: minimum count of accepted 1-votes for result = 1; legal range 1..4. The default matches the DOUBLE_TROUBLE function.
- TW, 16: timer width; must satisfy TIMEOUT < 2^TW.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin a round; sampled only in IDLE.
- vote_valid, input, 4: bit i = voter i presents a vote.
- vote_in, input, 4: bit i = voter i's vote value.
- vote_ack, output, 4: bit i = vote i accepted this cycle (combinational).
- busy, output, 1: high in COLLECT, EVAL and DONE.
- voted_mask, output, 4: registered; bit i = vote i accepted this round.
- res_valid, output, 1: registered; decision available.
- res_ready, input, 1: consumer accepts the decision.
- result, output, 1: registered; the threshold decision.
- timed_out, output, 1: registered; round closed with at least one vote missing.

Behaviour:
- Reset (async, rst_n = 0):
  - State goes to IDLE immediately.
  - voted_mask, vote register, timer, res_valid, result and timed_out clear to 0.
  - vote_ack = 0 and busy = 0.
  - Reset mid-round abandons the round; no result is produced.
- States: IDLE, COLLECT, EVAL, DONE. Transitions are one per clock.
- IDLE:
  - On start = 1: clear vote register and voted_mask, load timer = TIMEOUT, go to COLLECT.
  - On start = 0: stay.
- COLLECT:
  - vote_ack[i] = vote_valid[i] & ~voted_mask[i].
  - Each acked vote latches vote_in[i] into vote register bit i and sets voted_mask[i]. Any number of voters may be acked in the same cycle.
  - A repeated vote_valid from a voter already in the mask gets no ack and is ignored.
  - Timer decrements by 1 each COLLECT cycle.
  - Leave for EVAL when the next mask = 4'hF, or when timer = 1 (this is the last window cycle).
  - Votes acked in the closing cycle count.
  - start is ignored.
- EVAL (one cycle):
  - result <= (popcount(votes & voted_mask) >= THRESH).
  - timed_out <= (voted_mask != 4'hF).
  - res_valid <= 1. Go to DONE.
  - vote_ack = 0 in EVAL and DONE.
- DONE:
  - Hold result, timed_out and res_valid stable until res_ready = 1.
  - On that edge: res_valid <= 0 and go to IDLE; result, timed_out and voted_mask keep their values until the next start.
  - start is ignored.
- Latency, start at cycle 0 and all four votes valid at cycle 1: COLLECT at cycles 1..1, EVAL at cycle 2, res_valid = 1 from cycle 3.
- Maximum round: 1 + TIMEOUT + 1 cycles from start to res_valid.
- Back-to-back rounds: start is accepted in the IDLE cycle following the handshake. There is at least one IDLE cycle between rounds.
- No arithmetic overflow: popcount is 3 bits, range 0..4. Timer never wraps, because it reloads on start and exits at 1.

Test Plan:
- Reset then start; at cycle 1 vote_valid = 4'hF, vote_in = 4'b0011 -> vote_ack = 4'hF at cycle 1, res_valid = 1 at cycle 3, result = 1, timed_out = 0, voted_mask = 4'hF.
- Votes staggered: voter 0 = 1 at cycle 1, voter 2 = 0 at cycle 3, voter 1 = 0 at cycle 4, voter 3 = 0 at cycle 4 -> each ack is a single one-cycle pulse; result = 0 (one yes, THRESH = 2); res_valid two cycles after cycle 4.
- TIMEOUT = 4; only voters 1 and 3 vote 1, at cycle 2 -> round closes after COLLECT cycle 4; result = 1, timed_out = 1, voted_mask = 4'b1010.
- Voter 0 holds vote_valid high for 5 cycles with vote_in toggling -> a single ack on the first cycle; the first value is kept, later values ignored.
- Result hold: res_ready = 0 for 6 cycles, and start pulsed in DONE -> res_valid and result stay stable and no new round starts; res_ready = 1 -> IDLE next cycle, and a new start is accepted.
- rst_n pulled low mid-COLLECT with voted_mask = 4'b0101 -> all outputs 0 asynchronously; after release the block idles until start.
